// File: rtl/bcd_display_scanner.sv
// Binary-to-BCD converter (sequential double-dabble) feeding a multiplexed
// digit scanner with optional leading-zero blanking for a seven-segment display.
module bcd_display_scanner #(
    parameter int unsigned BIN_WIDTH     = 16,
    parameter int unsigned NUM_DIGITS    = 5,
    parameter int unsigned SCAN_DIV      = 50000,
    parameter int unsigned BLANK_LEADING = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [BIN_WIDTH-1:0]    value,
    input  logic                    load,
    output logic                    ready,
    output logic                    done,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [3:0]              bcd,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    blank
);

    localparam int unsigned BCD_W = 4 * NUM_DIGITS;
    localparam int unsigned CNT_W = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;
    localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    // True when 10^NUM_DIGITS > 2^BIN_WIDTH, i.e. floor(2^BIN_WIDTH / 10^NUM_DIGITS) == 0.
    function automatic bit range_ok();
        logic [1024:0] lim;
        lim            = '0;
        lim[BIN_WIDTH] = 1'b1;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            lim = lim / 1025'd10;
        end
        return lim == '0;
    endfunction

    if (!range_ok()) begin : g_range_check
        $fatal(1, "bcd_display_scanner: NUM_DIGITS too small for BIN_WIDTH");
    end
    if (SCAN_DIV < 1) begin : g_div_check
        $fatal(1, "bcd_display_scanner: SCAN_DIV must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;

    state_t               state;
    logic [BCD_W-1:0]     acc;
    logic [BCD_W-1:0]     acc_adj;
    logic [BIN_WIDTH-1:0] bin;
    logic [CNT_W-1:0]     iter;

    // Double-dabble correction: add 3 to every nibble >= 5 before the shift.
    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end
        end
    end

    // Converter FSM; ready rises one cycle after UPDATE so a new load cannot overlap done.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            ready  <= 1'b1;
            done   <= 1'b0;
            digits <= '0;
            acc    <= '0;
            bin    <= '0;
            iter   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (ready && load) begin
                        bin   <= value;
                        acc   <= '0;
                        iter  <= '0;
                        ready <= 1'b0;
                        state <= SHIFT;
                    end else begin
                        ready <= 1'b1;
                    end
                end
                SHIFT: begin
                    {acc, bin} <= {acc_adj[BCD_W-2:0], bin, 1'b0};
                    iter       <= iter + 1'b1;
                    if (iter == CNT_W'(BIN_WIDTH - 1)) begin
                        state <= UPDATE;
                    end
                end
                UPDATE: begin
                    digits <= acc;
                    done   <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [PRE_W-1:0] pre;
    logic [IDX_W-1:0] idx;

    // Free-running dwell prescaler and digit index.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre <= '0;
            idx <= '0;
        end else if (pre == PRE_W'(SCAN_DIV - 1)) begin
            pre <= '0;
            idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    logic [3:0] nib_c;
    logic       blank_c;
    logic       upper_zero;

    // Walk from the top digit down so upper_zero covers nibbles i..NUM_DIGITS-1.
    always_comb begin
        nib_c      = 4'd0;
        blank_c    = 1'b0;
        upper_zero = 1'b1;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            upper_zero = upper_zero && (digits[4*i +: 4] == 4'd0);
            if (idx == IDX_W'(i)) begin
                nib_c   = digits[4*i +: 4];
                blank_c = (BLANK_LEADING != 0) && (i != 0) && upper_zero;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bcd       <= 4'd0;
            digit_sel <= NUM_DIGITS'(1);
            blank     <= 1'b0;
        end else begin
            blank     <= blank_c;
            bcd       <= blank_c ? 4'd0 : nib_c;
            digit_sel <= blank_c ? '0 : (NUM_DIGITS'(1) << idx);
        end
    end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Randomized bench for bcd_display_scanner: arithmetic BCD model plus a
// cycle-count model of the digit scan, with blanking on and off side by side.
module tb_bcd_display_scanner;

    localparam int unsigned BW = 16;
    localparam int unsigned ND = 5;
    localparam int unsigned SD = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          load = 1'b0;
    logic [BW-1:0] value = '0;

    logic          ready_b, done_b, blank_b;
    logic [4*ND-1:0] digits_b;
    logic [3:0]    bcd_b;
    logic [ND-1:0] sel_b;
    logic          ready_n, done_n, blank_n;
    logic [4*ND-1:0] digits_n;
    logic [3:0]    bcd_n;
    logic [ND-1:0] sel_n;

    int t = 0;
    int passed = 0;
    int total = 0;

    bcd_display_scanner #(.BIN_WIDTH(BW), .NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_LEADING(1)) dut (
        .clk(clk), .reset(reset), .value(value), .load(load), .ready(ready_b), .done(done_b),
        .digits(digits_b), .bcd(bcd_b), .digit_sel(sel_b), .blank(blank_b)
    );

    bcd_display_scanner #(.BIN_WIDTH(BW), .NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_LEADING(0)) dut0 (
        .clk(clk), .reset(reset), .value(value), .load(load), .ready(ready_n), .done(done_n),
        .digits(digits_n), .bcd(bcd_n), .digit_sel(sel_n), .blank(blank_n)
    );

    always #5 clk = ~clk;

    // Edges since the last sampled reset; drives the scan model.
    always @(posedge clk) begin
        if (reset) t <= 0;
        else       t <= t + 1;
    end

    function automatic int pow10(input int n);
        int p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [4*ND-1:0] to_bcd(input int v);
        logic [4*ND-1:0] r = '0;
        for (int i = 0; i < int'(ND); i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
        return r;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    // Drive one load and record done/ready over the following 20 cycles.
    task automatic run_load(input int v, input int extra_at, input int extra_v,
                            output int done_at, output int done_cnt, output logic [19:0] rdy);
        done_at  = -1;
        done_cnt = 0;
        rdy      = '0;
        load  = 1'b1;
        value = BW'(v);
        tick();
        load = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            rdy[k-1] = ready_b;
            if (done_b) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
            if (k == extra_at - 1) begin
                load  = 1'b1;
                value = BW'(extra_v);
            end else begin
                load = 1'b0;
            end
        end
    endtask

    function automatic logic [19:0] exp_ready();
        logic [19:0] e = '0;
        for (int k = 1; k <= 20; k++) e[k-1] = (k >= 18);
        return e;
    endfunction

    task automatic test_scan(input int v, input int cycles);
        int idx, nib;
        logic blanked;
        logic [ND-1:0] es;
        for (int c = 0; c < cycles; c++) begin
            tick();
            if (t >= 1) begin
                idx     = ((t - 1) / int'(SD)) % int'(ND);
                nib     = (v / pow10(idx)) % 10;
                blanked = (idx > 0) && (v < pow10(idx));
                es      = blanked ? '0 : ND'(1 << idx);
                total++;
                if ({bcd_b, sel_b, blank_b} !== {blanked ? 4'd0 : 4'(nib), es, blanked}) begin
                    $display("FAIL scan_blank v=%0d t=%0d: got bcd=%0d sel=%b blank=%b, need bcd=%0d sel=%b blank=%b",
                             v, t, bcd_b, sel_b, blank_b, blanked ? 0 : nib, es, blanked);
                end else passed++;
                total++;
                if ({bcd_n, sel_n, blank_n} !== {4'(nib), ND'(1 << idx), 1'b0}) begin
                    $display("FAIL scan_noblank v=%0d t=%0d: got bcd=%0d sel=%b blank=%b, need bcd=%0d sel=%b blank=0",
                             v, t, bcd_n, sel_n, blank_n, nib, ND'(1 << idx));
                end else passed++;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        load  = 1'b1;
        value = BW'($urandom);
        repeat (3) tick();
        total++; if (ready_b !== 1'b1) $display("FAIL reset_ready: got %b need 1", ready_b); else passed++;
        total++; if (done_b !== 1'b0) $display("FAIL reset_done: got %b need 0", done_b); else passed++;
        total++; if (digits_b !== '0) $display("FAIL reset_digits: got %h need 0", digits_b); else passed++;
        total++; if (sel_b !== ND'(1)) $display("FAIL reset_sel: got %b need 00001", sel_b); else passed++;
        total++; if (bcd_b !== 4'd0) $display("FAIL reset_bcd: got %0d need 0", bcd_b); else passed++;
        total++; if (blank_b !== 1'b0) $display("FAIL reset_blank: got %b need 0", blank_b); else passed++;
        reset = 1'b0;
        load  = 1'b0;
        repeat (2) tick();
        total++;
        if ({ready_b, digits_b} !== {1'b1, 20'h0}) begin
            $display("FAIL reset_release: got ready=%b digits=%h need ready=1 digits=0", ready_b, digits_b);
        end else passed++;
    endtask

    task automatic test_convert(input int v, input int scan_cycles);
        int da, dc;
        logic [19:0] r;
        run_load(v, 0, 0, da, dc, r);
        total++; if (da !== 17) $display("FAIL conv_latency v=%0d: got %0d need 17", v, da); else passed++;
        total++; if (dc !== 1) $display("FAIL conv_done_count v=%0d: got %0d need 1", v, dc); else passed++;
        total++; if (r !== exp_ready()) $display("FAIL conv_ready v=%0d: got %b need %b", v, r, exp_ready()); else passed++;
        total++; if (digits_b !== to_bcd(v)) $display("FAIL conv_digits v=%0d: got %h need %h", v, digits_b, to_bcd(v)); else passed++;
        total++; if (digits_n !== to_bcd(v)) $display("FAIL conv_digits_nb v=%0d: got %h need %h", v, digits_n, to_bcd(v)); else passed++;
        test_scan(v, scan_cycles);
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) test_convert(int'($urandom_range(0, 65535)), int'(ND * SD));
    endtask

    task automatic test_busy_load();
        int da, dc;
        logic [19:0] r;
        run_load(42, 5, 9999, da, dc, r);
        total++; if (da !== 17) $display("FAIL busy_latency: got %0d need 17", da); else passed++;
        total++; if (dc !== 1) $display("FAIL busy_done_count: got %0d need 1", dc); else passed++;
        total++; if (digits_b !== to_bcd(42)) $display("FAIL busy_digits: got %h need %h", digits_b, to_bcd(42)); else passed++;
        total++; if (r !== exp_ready()) $display("FAIL busy_ready: got %b need %b", r, exp_ready()); else passed++;
        test_scan(42, int'(ND * SD));
    endtask

    task automatic test_abort();
        int dcount = 0;
        test_convert(7, 0);
        load  = 1'b1;
        value = BW'(1234);
        tick();
        load = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (done_b) dcount++;
        end
        total++; if (digits_b !== to_bcd(7)) $display("FAIL abort_hold: got %h need %h", digits_b, to_bcd(7)); else passed++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if (digits_b !== '0) $display("FAIL abort_digits: got %h need 0", digits_b); else passed++;
        total++; if (ready_b !== 1'b1) $display("FAIL abort_ready: got %b need 1", ready_b); else passed++;
        for (int k = 0; k < 20; k++) begin
            if (done_b) dcount++;
            tick();
        end
        total++; if (dcount !== 0) $display("FAIL abort_no_done: got %0d pulses need 0", dcount); else passed++;
        test_convert(7, int'(ND * SD));
    endtask

    initial begin
        test_reset();
        test_convert(1234, int'(2 * ND * SD + 3));
        test_convert(65535, int'(ND * SD));
        test_convert(0, int'(ND * SD));
        test_convert(1005, int'(ND * SD));
        test_random();
        test_busy_load();
        test_abort();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
